// File: rtl/sw_debounce8_pkg.sv
// Shared constants and payload types for the slide-switch debouncer.
package sw_debounce8_pkg;

  localparam int unsigned NUM_SW           = 8;
  localparam int unsigned DEFAULT_DEBOUNCE = 4;
  localparam int unsigned NUM_CH           = NUM_SW + 1;

  // Channel vector as seen by the downstream priority encoder.
  typedef struct packed {
    logic              en;
    logic [NUM_SW-1:0] x;
  } ch_vec_t;

endpackage

// File: rtl/sw_debounce8_debounce_bit.sv
// One debounce channel: two-flop synchronizer, saturating mismatch counter,
// stable register and a combinational update strobe.
module debounce_bit
  import sw_debounce8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic upd_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter restarts whenever the synchronized level agrees with stable.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    upd_c    = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        stable_d = sync2_q;
        upd_c    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/sw_debounce8.sv
// Debounces eight slide switches plus an enable switch feeding an 8-to-3
// priority encoder; changed pulses once per edge on which any output moved.
module sw_debounce8
  import sw_debounce8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              en_raw,
  output logic [NUM_SW-1:0] x,
  output logic              en,
  output logic              changed
);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] upd_c;
  ch_vec_t           stable_vec;
  logic              changed_q, changed_d;

  assign raw_vec = {en_raw, sw_raw};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_vec[i]),
      .stable(stable_vec[i]),
      .upd_c (upd_c[i])
    );
  end

  // Simultaneous channel updates collapse into a single pulse.
  always_comb begin
    changed_d = |upd_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign x       = stable_vec.x;
  assign en      = stable_vec.en;
  assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Directed bench for sw_debounce8 with DEBOUNCE_CYCLES=4 (update on edge 6).
module tb_sw_debounce8;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw_raw;
  logic       en_raw;
  logic [7:0] x;
  logic       en;
  logic       changed;

  int pass_cnt;
  int total_cnt;

  sw_debounce8 #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .en_raw (en_raw),
    .x      (x),
    .en     (en),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic test_reset();
    int seen;
    rst_n  = 1'b0;
    sw_raw = 8'h00;
    en_raw = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (x !== 8'h00) $display("FAIL reset_x: got %h expected 00", x); else pass_cnt++;
    total_cnt++;
    if (en !== 1'b0) $display("FAIL reset_en: got %b expected 0", en); else pass_cnt++;
    total_cnt++;
    if (changed !== 1'b0) $display("FAIL reset_changed: got %b expected 0", changed); else pass_cnt++;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (changed !== 1'b0) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL idle_changed: got %0d pulses expected 0", seen); else pass_cnt++;
    total_cnt++;
    if ({en, x} !== 9'h000) $display("FAIL idle_out: got %h expected 000", {en, x}); else pass_cnt++;
  endtask

  task automatic test_single();
    int early;
    sw_raw = 8'h12;
    early = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (x !== 8'h00 || changed !== 1'b0) early++;
    end
    total_cnt++;
    if (early !== 0) $display("FAIL x12_early: got %0d early updates expected 0", early); else pass_cnt++;
    tick();
    total_cnt++;
    if (x !== 8'h12) $display("FAIL x12_edge6: got %h expected 12", x); else pass_cnt++;
    total_cnt++;
    if (changed !== 1'b1) $display("FAIL x12_changed: got %b expected 1", changed); else pass_cnt++;
    tick();
    total_cnt++;
    if (changed !== 1'b0) $display("FAIL x12_pulse_width: got %b expected 0", changed); else pass_cnt++;
    en_raw = 1'b1;
    repeat (5) tick();
    total_cnt++;
    if (en !== 1'b0) $display("FAIL en_early: got %b expected 0", en); else pass_cnt++;
    tick();
    total_cnt++;
    if (en !== 1'b1 || changed !== 1'b1)
      $display("FAIL en_edge6: got en=%b changed=%b expected 1 1", en, changed);
    else pass_cnt++;
    total_cnt++;
    if (enc8(x) !== 3'd4) $display("FAIL encoder: got %0d expected 4", enc8(x)); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    sw_raw = 8'h92;
    repeat (3) begin
      tick();
      if (changed !== 1'b0) seen++;
    end
    sw_raw = 8'h12;
    repeat (10) begin
      tick();
      if (changed !== 1'b0 || x[7] !== 1'b0) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL glitch_filtered: got %0d bad cycles expected 0", seen); else pass_cnt++;
    total_cnt++;
    if (x !== 8'h12) $display("FAIL glitch_x: got %h expected 12", x); else pass_cnt++;
  endtask

  task automatic test_toggle();
    logic [4:0] pat;
    int early;
    pat = 5'b10101;
    early = 0;
    for (int k = 0; k < 5; k++) begin
      sw_raw[3] = pat[k];
      tick();
      if (x[3] !== 1'b0) early++;
    end
    repeat (4) begin
      tick();
      if (x[3] !== 1'b0 || changed !== 1'b0) early++;
    end
    total_cnt++;
    if (early !== 0) $display("FAIL toggle_early: got %0d early cycles expected 0", early); else pass_cnt++;
    tick();
    total_cnt++;
    if (x !== 8'h1A) $display("FAIL toggle_x: got %h expected 1a", x); else pass_cnt++;
    total_cnt++;
    if (changed !== 1'b1) $display("FAIL toggle_changed: got %b expected 1", changed); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int pulses;
    rst_n  = 1'b0;
    sw_raw = 8'h00;
    en_raw = 1'b0;
    tick();
    rst_n = 1'b1;
    en_raw = 1'b1;
    sw_raw = 8'h01;
    repeat (5) tick();
    total_cnt++;
    if ({en, x} !== 9'h000) $display("FAIL simul_early: got %h expected 000", {en, x}); else pass_cnt++;
    tick();
    total_cnt++;
    if ({en, x} !== 9'h101) $display("FAIL simul_edge6: got %h expected 101", {en, x}); else pass_cnt++;
    total_cnt++;
    if (changed !== 1'b1) $display("FAIL simul_changed: got %b expected 1", changed); else pass_cnt++;
    pulses = 0;
    repeat (5) begin
      tick();
      if (changed !== 1'b0) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL simul_single_pulse: got %0d extra expected 0", pulses); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad;
    sw_raw = 8'h80;
    en_raw = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({en, x} !== 9'h101) $display("FAIL mid_hold: got %h expected 101", {en, x}); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if ({en, x} !== 9'h000 || changed !== 1'b0)
      $display("FAIL mid_reset: got %h changed=%b expected 000 0", {en, x}, changed);
    else pass_cnt++;
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (x !== 8'h00 || changed !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL post_reset_early: got %0d bad cycles expected 0", bad); else pass_cnt++;
    tick();
    total_cnt++;
    if ({en, x} !== 9'h080 || changed !== 1'b1)
      $display("FAIL post_reset_edge6: got %h changed=%b expected 080 1", {en, x}, changed);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    sw_raw    = 8'h00;
    en_raw    = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_toggle();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
